// File: rtl/pacman_io_bridge_pkg.sv
// Shared definitions for the Pac-Man memory-mapped I/O bridge.
// Contents:
//   - address map of the bridge registers and the dmem RAM limit
//   - reset coordinates of players and powerups
//   - map clamp constants and the parked powerup coordinate
//   - direction encoding helper and the sprite overlap test
package pacman_io_bridge_pkg;

    // Address map
    localparam logic [16:0] RAM_LIMIT     = 17'd4096;
    localparam logic [16:0] ADDR_DIR0     = 17'd4100;
    localparam logic [16:0] ADDR_DIR1     = 17'd4101;
    localparam logic [16:0] ADDR_P0_X     = 17'd4200;
    localparam logic [16:0] ADDR_P0_Y     = 17'd4201;
    localparam logic [16:0] ADDR_P0_SPEED = 17'd4202;
    localparam logic [16:0] ADDR_P1_X     = 17'd4203;
    localparam logic [16:0] ADDR_P1_Y     = 17'd4204;
    localparam logic [16:0] ADDR_P1_SPEED = 17'd4205;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
    } pos_t;

    // Reset coordinates
    localparam pos_t P0_RESET  = '{x: 32'd260, y: 32'd240};
    localparam pos_t P1_RESET  = '{x: 32'd360, y: 32'd240};
    localparam pos_t PU0_RESET = '{x: 32'd300, y: 32'd300};
    localparam pos_t PU1_RESET = '{x: 32'd400, y: 32'd400};

    // Map clamp for player 0: top border and the wall block under it
    localparam logic [31:0] CLAMP_Y_MIN  = 32'd16;
    localparam logic [31:0] CLAMP_Y_WALL = 32'd72;
    localparam logic [31:0] WALL_X_LO    = 32'd133;
    localparam logic [31:0] WALL_X_HI    = 32'd184;

    // A picked-up powerup is moved off-map so it cannot be hit again
    localparam logic [31:0] PARKED     = 32'hFFFF_FFFF;
    localparam pos_t        PARKED_POS = '{x: PARKED, y: PARKED};

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_e;

    typedef struct packed {
        logic valid;
        dir_e code;
    } dir_t;

    // Exactly one or zero controller lines give a valid code; anything
    // else is ambiguous and the caller keeps its previous read value.
    function automatic dir_t decode_dir(input logic up, input logic right,
                                        input logic down, input logic left);
        dir_t r;
        r.valid = 1'b1;
        r.code  = DIR_NONE;
        case ({up, right, down, left})
            4'b0000: r.code  = DIR_NONE;
            4'b1000: r.code  = DIR_UP;
            4'b0100: r.code  = DIR_RIGHT;
            4'b0010: r.code  = DIR_DOWN;
            4'b0001: r.code  = DIR_LEFT;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Sprite overlap: either edge of the player lies within the powerup
    // span, on both axes. Sums wrap at 32 bits on purpose.
    function automatic logic overlap(input pos_t p, input pos_t u,
                                     input logic [31:0] w, input logic [31:0] h);
        logic [31:0] p_xe, u_xe, p_ye, u_ye;
        logic        hit_x, hit_y;
        p_xe  = p.x + w;
        u_xe  = u.x + w;
        p_ye  = p.y + h;
        u_ye  = u.y + h;
        hit_x = (p_xe >= u.x && p_xe <= u_xe) || (p.x >= u.x && p.x <= u_xe);
        hit_y = (p_ye >= u.y && p_ye <= u_ye) || (p.y >= u.y && p.y <= u_ye);
        return hit_x && hit_y;
    endfunction

endpackage

// File: rtl/pacman_io_bridge_if.sv
// Processor data-port / dmem bus seen by the I/O bridge.
// Signals:
//   address_dmem  processor data address
//   data          processor write data
//   wren          processor write enable
//   q_dmem        dmem read data
//   dmem_wren     gated dmem write enable (bridge output)
//   proc_data_in  registered read data to the processor (bridge output)
// Modports: slave = bridge side, master = processor/dmem side.
interface pacman_io_bridge_if;
    logic [16:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        dmem_wren;
    logic [31:0] proc_data_in;

    modport slave (
        input  address_dmem, data, wren, q_dmem,
        output dmem_wren, proc_data_in
    );

    modport master (
        output address_dmem, data, wren, q_dmem,
        input  dmem_wren, proc_data_in
    );
endinterface

// File: rtl/pacman_io_bridge_timer.sv
// powerup_timer: lifetime of one powerup effect.
// A pickup (start) raises the flag and enters stage 1. While a stage is
// running the tick counter advances; at TICKS_PER_STAGE it wraps and the
// stage advances. Reaching NUM_STAGES ends the effect.
// Ports:
//   clock   rising-edge clock
//   start   pickup pulse
//   clear   synchronous clear (driven by the bridge reset)
//   active  effect flag
module powerup_timer #(
    parameter int unsigned TICKS_PER_STAGE = 100000000,
    parameter int unsigned NUM_STAGES      = 8
) (
    input  logic clock,
    input  logic start,
    input  logic clear,
    output logic active
);
    localparam int CNT_W = $clog2(TICKS_PER_STAGE + 1);
    localparam int STG_W = $clog2(NUM_STAGES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic             active_q, active_d;

    // Later assignments deliberately override earlier ones; the end of
    // life wins even over a pickup in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        active_d = active_q;
        if (start) begin
            stage_d  = STG_W'(1);
            active_d = 1'b1;
        end
        if (stage_q != '0) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q == CNT_W'(TICKS_PER_STAGE)) begin
            stage_d = stage_q + STG_W'(1);
            cnt_d   = '0;
        end
        if (stage_q == STG_W'(NUM_STAGES)) begin
            stage_d  = '0;
            cnt_d    = '0;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (clear) begin
            cnt_q    <= '0;
            stage_q  <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
endmodule

// File: rtl/pacman_io_bridge.sv
// pacman_io_bridge: memory-mapped game I/O between the processor data
// port and dmem. Gates dmem writes to the RAM range, returns registered
// read data (RAM, controller directions, positions, speed flags) and owns
// the game state: player positions, player-0 map clamp, powerup pickup
// and powerup lifetimes.
// Ports:
//   clock, reset            clock (inverted processor clock), sync reset
//   bus                     processor/dmem bus (slave modport)
//   upSig..leftSig          player-0 controller
//   upSig2..leftSig2        player-1 controller
//   player0_x..player1_y    player positions
//   powerup0_x..powerup1_y  powerup positions
//   powerup1_active         shared fake-pellet effect flag
module pacman_io_bridge
    import pacman_io_bridge_pkg::*;
#(
    parameter int unsigned TICKS_PER_STAGE = 100000000,
    parameter int unsigned NUM_STAGES      = 8,
    parameter int unsigned SPRITE_W        = 28,
    parameter int unsigned SPRITE_H        = 28
) (
    input  logic                 clock,
    input  logic                 reset,
    pacman_io_bridge_if.slave    bus,
    input  logic                 upSig,
    input  logic                 rightSig,
    input  logic                 downSig,
    input  logic                 leftSig,
    input  logic                 upSig2,
    input  logic                 rightSig2,
    input  logic                 downSig2,
    input  logic                 leftSig2,
    output logic [31:0]          player0_x,
    output logic [31:0]          player0_y,
    output logic [31:0]          player1_x,
    output logic [31:0]          player1_y,
    output logic [31:0]          powerup0_x,
    output logic [31:0]          powerup0_y,
    output logic [31:0]          powerup1_x,
    output logic [31:0]          powerup1_y,
    output logic                 powerup1_active
);
    localparam logic [31:0] W32 = 32'(SPRITE_W);
    localparam logic [31:0] H32 = 32'(SPRITE_H);

    pos_t        tmp0_q, tmp0_d;
    pos_t        p0_q, p0_d;
    pos_t        p1_q, p1_d;
    pos_t        pu0_q, pu0_d;
    pos_t        pu1_q, pu1_d;
    logic [31:0] rd_q, rd_d;

    logic        hit_p0_pu0, hit_p1_pu0, hit_pellet;
    logic        speed0, speed1;
    dir_t        dir0, dir1;

    assign dir0 = decode_dir(upSig, rightSig, downSig, leftSig);
    assign dir1 = decode_dir(upSig2, rightSig2, downSig2, leftSig2);

    assign hit_p0_pu0 = overlap(p0_q, pu0_q, W32, H32);
    assign hit_p1_pu0 = overlap(p1_q, pu0_q, W32, H32);
    assign hit_pellet = overlap(p0_q, pu1_q, W32, H32) || overlap(p1_q, pu1_q, W32, H32);

    assign bus.dmem_wren = bus.wren && (bus.address_dmem < RAM_LIMIT);

    always_comb begin
        tmp0_d = tmp0_q;
        p1_d   = p1_q;
        pu0_d  = pu0_q;
        pu1_d  = pu1_q;
        rd_d   = rd_q;

        // Player-0 writes land in tmp0 and are clamped on the next edge;
        // player-1 writes go straight to the position.
        if (bus.wren) begin
            case (bus.address_dmem)
                ADDR_P0_X: tmp0_d.x = bus.data;
                ADDR_P0_Y: tmp0_d.y = bus.data;
                ADDR_P1_X: p1_d.x   = bus.data;
                ADDR_P1_Y: p1_d.y   = bus.data;
                default: ;
            endcase
        end

        // Clamp: top border, then the wall block spanning x 133..184.
        p0_d.x = tmp0_q.x;
        if (tmp0_q.y < CLAMP_Y_MIN) begin
            p0_d.y = CLAMP_Y_MIN;
        end else if (tmp0_q.y < CLAMP_Y_WALL && tmp0_q.x <= WALL_X_HI &&
                     (tmp0_q.x + W32) >= WALL_X_LO) begin
            p0_d.y = CLAMP_Y_WALL;
        end else begin
            p0_d.y = tmp0_q.y;
        end

        if (hit_p0_pu0 || hit_p1_pu0) pu0_d = PARKED_POS;
        if (hit_pellet)               pu1_d = PARKED_POS;

        // Read mux; unmatched cases keep the previous read value.
        if (bus.address_dmem < RAM_LIMIT) begin
            rd_d = bus.q_dmem;
        end else begin
            case (bus.address_dmem)
                ADDR_DIR0: if (dir0.valid) rd_d = {29'd0, dir0.code};
                ADDR_DIR1: if (dir1.valid) rd_d = {29'd0, dir1.code};
                ADDR_P0_X:     if (!bus.wren) rd_d = p0_q.x;
                ADDR_P0_Y:     if (!bus.wren) rd_d = p0_q.y;
                ADDR_P0_SPEED: if (!bus.wren) rd_d = {31'd0, speed0};
                ADDR_P1_X:     if (!bus.wren) rd_d = p1_q.x;
                ADDR_P1_Y:     if (!bus.wren) rd_d = p1_q.y;
                ADDR_P1_SPEED: if (!bus.wren) rd_d = {31'd0, speed1};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmp0_q <= P0_RESET;
            p0_q   <= P0_RESET;
            p1_q   <= P1_RESET;
            pu0_q  <= PU0_RESET;
            pu1_q  <= PU1_RESET;
            rd_q   <= '0;
        end else begin
            tmp0_q <= tmp0_d;
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            pu0_q  <= pu0_d;
            pu1_q  <= pu1_d;
            rd_q   <= rd_d;
        end
    end

    powerup_timer #(.TICKS_PER_STAGE(TICKS_PER_STAGE), .NUM_STAGES(NUM_STAGES)) u_speed0 (
        .clock (clock),
        .start (hit_p0_pu0),
        .clear (reset),
        .active(speed0)
    );

    powerup_timer #(.TICKS_PER_STAGE(TICKS_PER_STAGE), .NUM_STAGES(NUM_STAGES)) u_speed1 (
        .clock (clock),
        .start (hit_p1_pu0),
        .clear (reset),
        .active(speed1)
    );

    powerup_timer #(.TICKS_PER_STAGE(TICKS_PER_STAGE), .NUM_STAGES(NUM_STAGES)) u_pellet (
        .clock (clock),
        .start (hit_pellet),
        .clear (reset),
        .active(powerup1_active)
    );

    assign bus.proc_data_in = rd_q;
    assign player0_x  = p0_q.x;
    assign player0_y  = p0_q.y;
    assign player1_x  = p1_q.x;
    assign player1_y  = p1_q.y;
    assign powerup0_x = pu0_q.x;
    assign powerup0_y = pu0_q.y;
    assign powerup1_x = pu1_q.x;
    assign powerup1_y = pu1_q.y;
endmodule

// File: tb/tb_pacman_io_bridge.sv
// Directed bench for pacman_io_bridge with TICKS_PER_STAGE=4, NUM_STAGES=8,
// so a powerup stays active for 7*5+1 = 36 edges.
module tb_pacman_io_bridge;
    logic clock;
    logic reset;
    logic upSig, rightSig, downSig, leftSig;
    logic upSig2, rightSig2, downSig2, leftSig2;
    logic [31:0] player0_x, player0_y, player1_x, player1_y;
    logic [31:0] powerup0_x, powerup0_y, powerup1_x, powerup1_y;
    logic        powerup1_active;

    int checks   = 0;
    int failures = 0;

    pacman_io_bridge_if bus ();

    pacman_io_bridge #(
        .TICKS_PER_STAGE(4),
        .NUM_STAGES     (8),
        .SPRITE_W       (28),
        .SPRITE_H       (28)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .upSig          (upSig),
        .rightSig       (rightSig),
        .downSig        (downSig),
        .leftSig        (leftSig),
        .upSig2         (upSig2),
        .rightSig2      (rightSig2),
        .downSig2       (downSig2),
        .leftSig2       (leftSig2),
        .player0_x      (player0_x),
        .player0_y      (player0_y),
        .player1_x      (player1_x),
        .player1_y      (player1_y),
        .powerup0_x     (powerup0_x),
        .powerup0_y     (powerup0_y),
        .powerup1_x     (powerup1_x),
        .powerup1_y     (powerup1_y),
        .powerup1_active(powerup1_active)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [16:0] addr, input logic [31:0] value);
        bus.address_dmem = addr;
        bus.data         = value;
        bus.wren         = 1'b1;
        tick();
        bus.wren         = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {upSig, rightSig, downSig, leftSig}     = '0;
        {upSig2, rightSig2, downSig2, leftSig2} = '0;
        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        bus.q_dmem       = '0;
        tick(2);

        // Reset defaults
        check("rst_p0_x", player0_x, 32'd260);
        check("rst_p0_y", player0_y, 32'd240);
        check("rst_p1_x", player1_x, 32'd360);
        check("rst_p1_y", player1_y, 32'd240);
        check("rst_pu0_x", powerup0_x, 32'd300);
        check("rst_pu0_y", powerup0_y, 32'd300);
        check("rst_pu1_x", powerup1_x, 32'd400);
        check("rst_pu1_y", powerup1_y, 32'd400);
        check("rst_active", {31'd0, powerup1_active}, 32'd0);
        check("rst_rd", bus.proc_data_in, 32'd0);
        reset = 1'b0;

        // Direction codes
        bus.address_dmem = 17'd4100;
        rightSig = 1'b1;
        tick();
        check("dir0_right", bus.proc_data_in, 32'd2);
        rightSig = 1'b0; upSig = 1'b1; leftSig = 1'b1;
        tick();
        check("dir0_multi_hold", bus.proc_data_in, 32'd2);
        upSig = 1'b0; leftSig = 1'b0;
        tick();
        check("dir0_none", bus.proc_data_in, 32'd0);
        leftSig = 1'b1;
        tick();
        check("dir0_left", bus.proc_data_in, 32'd4);
        leftSig = 1'b0;
        bus.address_dmem = 17'd4101;
        downSig2 = 1'b1;
        tick();
        check("dir1_down", bus.proc_data_in, 32'd3);
        rightSig2 = 1'b1;
        tick();
        check("dir1_multi_hold", bus.proc_data_in, 32'd3);
        downSig2 = 1'b0; rightSig2 = 1'b0;

        // Position reads; reads of 4200-4205 hold while wren is high
        bus.address_dmem = 17'd4200;
        tick();
        check("rd_p0_x", bus.proc_data_in, 32'd260);
        bus.address_dmem = 17'd4203;
        tick();
        check("rd_p1_x", bus.proc_data_in, 32'd360);
        bus.address_dmem = 17'd4202;
        bus.wren = 1'b1;
        tick();
        check("rd_hold_on_write", bus.proc_data_in, 32'd360);
        bus.wren = 1'b0;

        // Write gating and two-edge clamp path
        bus.address_dmem = 17'd4201;
        bus.data = 32'd5;
        bus.wren = 1'b1;
        #1;
        check("gate_4201", {31'd0, bus.dmem_wren}, 32'd0);
        tick();
        bus.wren = 1'b0;
        check("clamp_lat_1", player0_y, 32'd240);
        tick();
        check("clamp_top", player0_y, 32'd16);
        check("clamp_top_x", player0_x, 32'd260);

        wr(17'd4200, 32'd150);
        wr(17'd4201, 32'd50);
        tick();
        check("clamp_wall_x", player0_x, 32'd150);
        check("clamp_wall_y", player0_y, 32'd72);
        wr(17'd4200, 32'd300);
        tick();
        check("clamp_open_y", player0_y, 32'd50);
        wr(17'd4200, 32'd184);
        tick();
        check("clamp_wall_hi_edge", player0_y, 32'd72);
        wr(17'd4200, 32'd105);
        tick();
        check("clamp_wall_lo_edge", player0_y, 32'd72);
        wr(17'd4200, 32'd104);
        tick();
        check("clamp_wall_lo_out", player0_y, 32'd50);

        // Speed pickup by player 1 on powerup0 at (300,300)
        wr(17'd4203, 32'd310);
        check("p1_x_direct", player1_x, 32'd310);
        bus.address_dmem = 17'd4204;
        bus.data = 32'd310;
        bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
        check("p1_y_direct", player1_y, 32'd310);
        check("pu0_not_yet", powerup0_x, 32'd300);
        bus.address_dmem = 17'd4205;
        tick();
        check("pu0_parked_x", powerup0_x, 32'hFFFF_FFFF);
        check("pu0_parked_y", powerup0_y, 32'hFFFF_FFFF);
        check("speed1_pre", bus.proc_data_in, 32'd0);
        check("pellet_idle", {31'd0, powerup1_active}, 32'd0);
        for (int i = 1; i <= 35; i++) begin
            bus.address_dmem = (i % 2 == 1) ? 17'd4202 : 17'd4205;
            tick();
            if (i % 2 == 1) check("speed0_stays_0", bus.proc_data_in, 32'd0);
            else            check("speed1_high", bus.proc_data_in, 32'd1);
        end
        bus.address_dmem = 17'd4205;
        tick();
        check("speed1_last", bus.proc_data_in, 32'd1);
        tick();
        check("speed1_expired", bus.proc_data_in, 32'd0);

        // Pellet pickup by player 0 on powerup1 at (400,400)
        wr(17'd4200, 32'd400);
        wr(17'd4201, 32'd400);
        bus.address_dmem = 17'd100;
        tick();
        check("p0_on_pellet_x", player0_x, 32'd400);
        check("p0_on_pellet_y", player0_y, 32'd400);
        check("pellet_not_yet", {31'd0, powerup1_active}, 32'd0);
        tick();
        check("pellet_on", {31'd0, powerup1_active}, 32'd1);
        check("pu1_parked_x", powerup1_x, 32'hFFFF_FFFF);
        check("pu1_parked_y", powerup1_y, 32'hFFFF_FFFF);
        for (int k = 1; k <= 35; k++) begin
            tick();
            check("pellet_high", {31'd0, powerup1_active}, 32'd1);
        end
        tick();
        check("pellet_expired", {31'd0, powerup1_active}, 32'd0);
        check("pu0_still_parked", powerup0_x, 32'hFFFF_FFFF);

        // RAM path and RAM boundary
        bus.address_dmem = 17'd100;
        bus.wren = 1'b1;
        #1;
        check("ram_wren", {31'd0, bus.dmem_wren}, 32'd1);
        bus.address_dmem = 17'd4095;
        #1;
        check("ram_wren_top", {31'd0, bus.dmem_wren}, 32'd1);
        bus.address_dmem = 17'd4096;
        #1;
        check("ram_wren_above", {31'd0, bus.dmem_wren}, 32'd0);
        bus.wren = 1'b0;
        bus.address_dmem = 17'd100;
        bus.q_dmem = 32'hDEAD_BEEF;
        tick();
        check("ram_read", bus.proc_data_in, 32'hDEAD_BEEF);
        bus.address_dmem = 17'd4096;
        bus.q_dmem = 32'h1234_5678;
        tick();
        check("unmapped_hold", bus.proc_data_in, 32'hDEAD_BEEF);

        // Reset restores every state register
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rerst_p0_y", player0_y, 32'd240);
        check("rerst_p1_x", player1_x, 32'd360);
        check("rerst_pu0_x", powerup0_x, 32'd300);
        check("rerst_pu1_y", powerup1_y, 32'd400);
        check("rerst_rd", bus.proc_data_in, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pacman_io_bridge.md
# pacman_io_bridge

Memory-mapped game I/O bridge between the `processor` data port and `dmem`, also sitting alongside `imem` in the system top. It decodes the processor's data address and gates dmem writes to the RAM range. It returns RAM data, controller directions, player positions or powerup flags as registered read data. It also owns the game-state registers: player positions, player-0 map clamping, powerup pickup detection and powerup lifetimes.

## Interface
- `TICKS_PER_STAGE`, default 100000000: counter terminal value per lifetime stage.
- `NUM_STAGES`, default 8: stage value that ends a powerup.
- `SPRITE_W`, default 28: sprite width in pixels.
- `SPRITE_H`, default 28: sprite height in pixels.
- `clock`  in  1: single clock. All state updates on the rising edge; the top level feeds the inverted processor clock.
- `reset`  in  1: synchronous, active-high.
- `address_dmem`  in  17: processor data address.
- `data`  in  32: processor write data.
- `wren`  in  1: processor write enable.
- `q_dmem`  in  32: dmem read data.
- `upSig`, `rightSig`, `downSig`, `leftSig`  in  1 each: player-0 controller.
- `upSig2`, `rightSig2`, `downSig2`, `leftSig2`  in  1 each: player-1 controller.
- `dmem_wren`  out  1: `wren` when `address_dmem` < 4096, else 0. Combinational.
- `proc_data_in`  out  32: registered read data to the processor.
- `player0_x`, `player0_y`, `player1_x`, `player1_y`  out  32 each: player positions.
- `powerup0_x`, `powerup0_y`, `powerup1_x`, `powerup1_y`  out  32 each: powerup positions.
- `powerup1_active`  out  1: fake-pellet powerup is active (shared by both players).

## Operation
- **Read mux**, registered every cycle:
  - addr < 4096: `q_dmem`.
  - 4100: direction code from the player-0 signals. Exactly up → 1, right → 2, down → 3, left → 4; none asserted → 0. Two or more asserted → hold the previous value.
  - 4101: the same encoding from the player-1 signals.
  - 4200 / 4201: `player0_x` / `player0_y`.
  - 4202: player-0 speed flag, zero-extended.
  - 4203 / 4204: `player1_x` / `player1_y`.
  - 4205: player-1 speed flag, zero-extended.
  - Addresses 4200–4205 are returned only when `wren`=0. Any other case holds the previous value.
- **Writes**, when `wren`=1:
  - 4200 → `tmp0_x`; 4201 → `tmp0_y`.
  - 4203 → `player1_x`; 4204 → `player1_y`, written directly.
  - No other address ≥ 4096 has a write effect.
- **Player-0 clamp**, every cycle:
  - `player0_x` ← `tmp0_x`.
  - `player0_y` ← 16 if `tmp0_y` < 16.
  - Else 72 if `tmp0_y` < 72 and `tmp0_x` ≤ 184 and `tmp0_x`+W ≥ 133.
  - Else `tmp0_y`.
- **Overlap(p,u)**: ((px+W ≥ ux and px+W ≤ ux+W) or (px ≥ ux and px ≤ ux+W)) and the same test on y with H. All comparisons are 32-bit unsigned, and sums wrap modulo 2^32.
- **Pickup**:
  - Overlap(player n, powerup0) → powerup0 x,y ← 0xFFFFFFFF; speed flag n ← 1; stage n ← 1.
  - Overlap(either player, powerup1) → powerup1 x,y ← 0xFFFFFFFF; `powerup1_active` ← 1; shared stage ← 1.
  - Both players may pick up powerup0 in the same cycle; both flags set.
- **Lifetime**, applied per stage/counter pair in this priority order, last wins:
  1. Pickup sets.
  2. If stage > 0, counter+1.
  3. If counter == `TICKS_PER_STAGE`, stage+1 and counter ← 0.
  4. If stage == `NUM_STAGES`, stage ← 0, counter ← 0, flag ← 0. This overrides a simultaneous pickup.

## Timing
- Reset values:
  - player0 = tmp0 = (260,240); player1 = (360,240).
  - powerup0 = (300,300); powerup1 = (400,400).
  - All flags, stages, counters and `proc_data_in` = 0.
- Read latency: 1 edge, address to `proc_data_in`.
- A write to 4200/4201 reaches `player0_*` 2 edges after issue: `tmp0` updates, then the clamp registers it. Writes to 4203/4204 appear after 1 edge.
- The flag goes high at the pickup edge E and clears at edge E + (NUM_STAGES−1)·(TICKS_PER_STAGE+1) + 1.
- A parked powerup at 0xFFFFFFFF never re-triggers for coordinates < 0xFFFFFFFF−W.
- Reset mid-lifetime restores all reset values on that edge.

## Structure
- Shared package holds:
  - Address constants: 4096, 4100, 4101, 4200–4205.
  - Reset coordinates.
  - Map clamp constants: 16, 72, 133, 184.
  - Parked coordinate 0xFFFFFFFF.
- One sub-module `powerup_timer` holds one stage counter, one tick counter and the flag, with inputs `start` and `clear`. Instantiate it three times: p0 speed, p1 speed, shared pellet.
- The overlap test is a function in the package.

## Test plan
All tests use TICKS_PER_STAGE=4.
1. **Reset defaults:** after reset → player0 (260,240), player1 (360,240), powerup0 (300,300), powerup1 (400,400), all flags 0.
2. **Direction codes:**
   - addr 4100 with rightSig only → `proc_data_in`=2 next edge.
   - No signals → 0.
   - up+left → previous value held.
   - addr 4101 with downSig2 → 3.
3. **Write gating and clamp:**
   - Write 4201 = 5 → `dmem_wren`=0; 2 edges later `player0_y`=16.
   - Write x=150, y=50 → `player0_y`=72.
   - Write x=300, y=50 → `player0_y`=50.
4. **Speed pickup:**
   - Write player1 = (310,310) → powerup0 = 0xFFFFFFFF next edge; 4205 reads 1.
   - Flag stays high 36 cycles, then 0; 4202 stays 0 throughout.
5. **Pellet pickup:** move player0 onto (400,400) → `powerup1_active`=1 for 36 cycles; powerup1 parked.
6. **RAM path:** addr 100, `wren`=1 → `dmem_wren`=1; addr 100 read → `proc_data_in` = `q_dmem` one edge later.
